// File: rtl/spi_arbiter_if.sv
// Requester and SPI-master signal bundle for spi_arbiter; slave = arbiter view,
// master = requesters plus SPI master (the environment around the arbiter).
interface spi_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   rsp_valid;
    logic [7:0]         rsp_data;
    logic               rsp_err;
    logic               spi_start;
    logic [7:0]         spi_tx_data;
    logic [7:0]         spi_rx_data;
    logic               spi_busy;
    logic               spi_done;
    logic [N_REQ-1:0]   cs_sel;

    modport slave (
        input  req_valid, req_data, spi_rx_data, spi_busy, spi_done,
        output req_ready, rsp_valid, rsp_data, rsp_err, spi_start, spi_tx_data, cs_sel
    );

    modport master (
        output req_valid, req_data, spi_rx_data, spi_busy, spi_done,
        input  req_ready, rsp_valid, rsp_data, rsp_err, spi_start, spi_tx_data, cs_sel
    );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among N_REQ byte requesters; accept T, spi_start T+1, rsp T+2+k.
// Backpressure: req_ready only in IDLE with spi_busy low; one transfer in flight, WAIT bounded by TIMEOUT.
module spi_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_arbiter_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   winner;
    logic [15:0]        cnt;
    logic [15:0]        cnt_next;

    logic               spi_start_q;
    logic [7:0]         spi_tx_q;
    logic [N_REQ-1:0]   cs_sel_q;
    logic [N_REQ-1:0]   rsp_valid_q;
    logic [7:0]         rsp_data_q;
    logic               rsp_err_q;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [N_REQ-1:0]   req_ready_c;
    int                 cand;
    logic [IDX_W-1:0]   cand_idx;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand     = (int'(last_grant) + off) % N_REQ;
            cand_idx = IDX_W'(cand);
            if (!win_found && bus.req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Gated by rst_n so the strobe is also forced low asynchronously.
    assign req_ready_c = (rst_n && (state == IDLE) && !bus.spi_busy && win_found)
                         ? (ONE << win_idx) : '0;

    assign cnt_next = cnt + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= IDX_W'(N_REQ - 1);
            winner      <= '0;
            cnt         <= '0;
            spi_start_q <= 1'b0;
            spi_tx_q    <= '0;
            cs_sel_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_ready_c) begin
                        winner      <= win_idx;
                        spi_tx_q    <= bus.req_data[{win_idx, 3'b000} +: 8];
                        cs_sel_q    <= req_ready_c;
                        spi_start_q <= 1'b1;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    spi_start_q <= 1'b0;
                    cnt         <= '0;
                    state       <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the timeout cycle still counts as success.
                    if (bus.spi_done) begin
                        rsp_data_q  <= bus.spi_rx_data;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= cs_sel_q;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt_next;
                        if (cnt_next == 16'(TIMEOUT)) begin
                            rsp_data_q  <= 8'h00;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= cs_sel_q;
                            state       <= RESP;
                        end
                    end
                end
                RESP: begin
                    rsp_valid_q <= '0;
                    rsp_data_q  <= '0;
                    rsp_err_q   <= 1'b0;
                    cs_sel_q    <= '0;
                    spi_tx_q    <= '0;
                    last_grant  <= winner;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.spi_start   = spi_start_q;
    assign bus.spi_tx_data = spi_tx_q;
    assign bus.cs_sel      = cs_sel_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter (N_REQ=4, TIMEOUT=255); inputs driven and outputs sampled near negedge.
module tb_spi_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_arbiter_if #(.N_REQ(4)) bus ();

    spi_arbiter #(.N_REQ(4), .TIMEOUT(255)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] DATA4 = {8'h43, 8'h32, 8'h21, 8'h10};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    // Entered at a negedge with requests already driven; returns at the negedge after RESP.
    // k = cycles from spi_start to the cycle spi_done is driven (or to the last WAIT cycle).
    task automatic xfer(input string tag, input int w, input logic [7:0] tx, input int k,
                        input logic [7:0] rx, input bit give_done, input bit drop);
        #1;
        check({tag, ".ready"}, 32'(bus.req_ready), 32'(oh(w)));
        @(negedge clk);
        if (drop) bus.req_valid[w] = 1'b0;
        #1;
        check({tag, ".start"},    32'(bus.spi_start),   32'd1);
        check({tag, ".tx"},       32'(bus.spi_tx_data), 32'(tx));
        check({tag, ".cs"},       32'(bus.cs_sel),      32'(oh(w)));
        check({tag, ".ready_lo"}, 32'(bus.req_ready),   32'd0);
        for (int j = 1; j < k; j++) @(negedge clk);
        @(negedge clk);
        bus.spi_rx_data = rx;
        if (give_done) bus.spi_done = 1'b1;
        #1;
        check({tag, ".rsp_early"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, ".start_lo"},  32'(bus.spi_start), 32'd0);
        @(negedge clk);
        bus.spi_done    = 1'b0;
        bus.spi_rx_data = 8'hEE;
        #1;
        check({tag, ".rsp_vld"},  32'(bus.rsp_valid),   32'(oh(w)));
        check({tag, ".rsp_dat"},  32'(bus.rsp_data),    give_done ? 32'(rx) : 32'd0);
        check({tag, ".rsp_err"},  32'(bus.rsp_err),     give_done ? 32'd0 : 32'd1);
        check({tag, ".cs_hold"},  32'(bus.cs_sel),      32'(oh(w)));
        check({tag, ".tx_hold"},  32'(bus.spi_tx_data), 32'(tx));
        @(negedge clk);
        #1;
        check({tag, ".rsp_lo"},   32'(bus.rsp_valid),   32'd0);
        check({tag, ".cs_lo"},    32'(bus.cs_sel),      32'd0);
        check({tag, ".tx_lo"},    32'(bus.spi_tx_data), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.req_valid   = 4'b1111;
        bus.req_data    = DATA4;
        bus.spi_rx_data = 8'h00;
        bus.spi_busy    = 1'b0;
        bus.spi_done    = 1'b0;
        #1;
        check("rst.ready", 32'(bus.req_ready),   32'd0);
        check("rst.rsp",   32'(bus.rsp_valid),   32'd0);
        check("rst.dat",   32'(bus.rsp_data),    32'd0);
        check("rst.err",   32'(bus.rsp_err),     32'd0);
        check("rst.start", 32'(bus.spi_start),   32'd0);
        check("rst.tx",    32'(bus.spi_tx_data), 32'd0);
        check("rst.cs",    32'(bus.cs_sel),      32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // All four requesting continuously: grants rotate 0,1,2,3,0.
        xfer("rr0", 0, 8'h10, 1, 8'hA0, 1'b1, 1'b0);
        xfer("rr1", 1, 8'h21, 2, 8'hA1, 1'b1, 1'b0);
        xfer("rr2", 2, 8'h32, 3, 8'hA2, 1'b1, 1'b0);
        xfer("rr3", 3, 8'h43, 4, 8'hA3, 1'b1, 1'b0);
        xfer("rr4", 0, 8'h10, 1, 8'hA4, 1'b1, 1'b0);
        bus.req_valid = 4'b0000;

        // Sole requester wins back-to-back slots.
        bus.req_valid = 4'b0010;
        xfer("sole0", 1, 8'h21, 2, 8'hB1, 1'b1, 1'b0);
        xfer("sole1", 1, 8'h21, 2, 8'hB2, 1'b1, 1'b0);
        bus.req_valid = 4'b0000;

        // Single request, done 16 cycles after spi_start.
        bus.req_valid = 4'b0100;
        bus.req_data  = {8'h43, 8'hA5, 8'h21, 8'h10};
        xfer("single", 2, 8'hA5, 16, 8'h3C, 1'b1, 1'b1);
        bus.req_data  = DATA4;

        // Request withdrawn before any clock edge: nothing starts.
        bus.req_valid = 4'b0001;
        #1;
        check("wdraw.ready", 32'(bus.req_ready), 32'(oh(0)));
        bus.req_valid = 4'b0000;
        @(negedge clk);
        #1;
        check("wdraw.start", 32'(bus.spi_start), 32'd0);
        check("wdraw.cs",    32'(bus.cs_sel),    32'd0);

        // spi_busy holds off grants; a stray spi_done in IDLE is ignored.
        bus.spi_busy  = 1'b1;
        bus.req_valid = 4'b1000;
        bus.req_data  = {8'hB4, 8'h32, 8'h21, 8'h10};
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            bus.spi_done    = (j == 1);
            bus.spi_rx_data = 8'h11;
            #1;
            check("busy.ready", 32'(bus.req_ready), 32'd0);
            check("busy.rsp",   32'(bus.rsp_valid), 32'd0);
        end
        @(negedge clk);
        bus.spi_done = 1'b0;
        #1;
        check("busy.rsp_after", 32'(bus.rsp_valid), 32'd0);
        bus.spi_busy = 1'b0;
        xfer("busy", 3, 8'hB4, 2, 8'h22, 1'b1, 1'b1);

        // spi_done on the very cycle the count reaches TIMEOUT: success wins.
        bus.req_valid = 4'b1000;
        bus.req_data  = {8'h77, 8'h32, 8'h21, 8'h10};
        xfer("edge", 3, 8'h77, 255, 8'hC3, 1'b1, 1'b1);

        // No spi_done at all: error response after 255 WAIT cycles.
        bus.req_valid = 4'b0001;
        bus.req_data  = {8'h43, 8'h32, 8'h21, 8'h5A};
        xfer("tmo", 0, 8'h5A, 255, 8'h66, 1'b0, 1'b1);
        bus.req_data  = DATA4;

        // Reset during WAIT aborts; first grant afterwards goes to requester 0.
        bus.req_valid = 4'b0010;
        #1;
        check("abort.ready", 32'(bus.req_ready), 32'(oh(1)));
        @(negedge clk);
        bus.req_valid = 4'b0000;
        repeat (5) @(negedge clk);
        rst_n           = 1'b0;
        bus.spi_done    = 1'b1;
        bus.spi_rx_data = 8'h55;
        #1;
        check("abort.cs",    32'(bus.cs_sel),      32'd0);
        check("abort.tx",    32'(bus.spi_tx_data), 32'd0);
        check("abort.start", 32'(bus.spi_start),   32'd0);
        check("abort.rsp",   32'(bus.rsp_valid),   32'd0);
        @(negedge clk);
        bus.spi_done = 1'b0;
        #1;
        check("abort.rsp2", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.req_valid = 4'b1111;
        xfer("post_rst", 0, 8'h10, 3, 8'h9E, 1'b1, 1'b1);
        bus.req_valid = 4'b0000;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (legal range 2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of WAIT cycles for spi_done (legal range 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, N_REQ bits: per-requester byte-transfer request.
REQ-006 The block SHALL have port req_data, input, 8*N_REQ bits: tx byte, with requester i at [8i+7:8i].
REQ-007 The block SHALL have port req_ready, output, N_REQ bits: acceptance strobe, at most one bit set.
REQ-008 The block SHALL have port rsp_valid, output, N_REQ bits: one-cycle completion strobe to the granted requester.
REQ-009 The block SHALL have port rsp_data, output, 8 bits: received byte, valid with rsp_valid.
REQ-010 The block SHALL have port rsp_err, output, 1 bit: timeout flag, valid with rsp_valid.
REQ-011 The block SHALL have ports spi_start (output, 1) and spi_tx_data (output, 8), which drive the SPI master start/tx_data.
REQ-012 The block SHALL have ports spi_rx_data (input, 8), spi_busy (input, 1) and spi_done (input, 1), which come from the SPI master.
REQ-013 The block SHALL have port cs_sel, output, N_REQ bits: one-hot slave select for the granted requester, active-high.

Function
REQ-014 The block SHALL implement FSM states IDLE, LAUNCH, WAIT and RESP, one per cycle except WAIT.
REQ-015 In IDLE with spi_busy=0 and any req_valid=1, the block SHALL assert req_ready for exactly one winner, chosen combinationally by round-robin starting at last_grant+1 (mod N_REQ).
REQ-016 A transfer SHALL be accepted when req_valid[w] and req_ready[w] are both 1: req_data[w] and the winner index are latched, and the next state is LAUNCH.
REQ-017 In IDLE with spi_busy=1, req_ready SHALL be all-zero and the block SHALL stay in IDLE.
REQ-018 In any state other than IDLE, req_ready SHALL be all-zero.
REQ-019 In LAUNCH, spi_start SHALL be 1 for exactly one cycle, the timeout counter SHALL clear, and the next state SHALL be WAIT.
REQ-020 spi_tx_data SHALL hold the latched byte from LAUNCH through RESP; cs_sel SHALL be one-hot of the winner over the same span and 0 otherwise.
REQ-021 In WAIT with spi_done=1, the block SHALL latch spi_rx_data, clear the error flag, and go to RESP.
REQ-022 In WAIT with spi_done=0, the counter SHALL increment; when it reaches TIMEOUT, the error flag SHALL set, rsp_data SHALL be 0x00, and the next state SHALL be RESP.
REQ-023 If spi_done and the timeout occur in the same cycle, spi_done SHALL win and rsp_err SHALL be 0.
REQ-024 In RESP, rsp_valid[winner] SHALL be 1 for one cycle together with rsp_data/rsp_err, last_grant SHALL become winner, and the next state SHALL be IDLE.
REQ-025 spi_done in any state other than WAIT SHALL be ignored.
REQ-026 Latency SHALL be: accept at cycle T, spi_start at T+1, spi_done at T+1+k (k≥1), rsp_valid at T+2+k.
REQ-027 The earliest next accept SHALL be the cycle after RESP.
REQ-028 Requesters SHALL hold req_valid and req_data until accepted; deassertion before acceptance withdraws the request with no side effect.
REQ-029 With continuous requests from all requesters, grants SHALL rotate 0,1,...,N_REQ-1,0; a sole requester SHALL win every slot.

Reset
REQ-030 While rst_n=0, the block SHALL be in state IDLE, last_grant SHALL be N_REQ-1 (so requester 0 has first priority), the counter SHALL be 0, and all outputs (req_ready, rsp_valid, rsp_data, rsp_err, spi_start, spi_tx_data, cs_sel) SHALL be 0, asynchronously.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer with no rsp_valid; after release, the block SHALL resume from IDLE.

Verification
REQ-032 Single request: req_valid[2]=1, data 0xA5, done after 16 cycles with rx 0x3C -> req_ready[2] for 1 cycle, spi_start 1 cycle later with tx 0xA5, cs_sel=0b0100, rsp_valid[2] with rsp_data 0x3C, rsp_err=0.
REQ-033 All four requesting continuously from reset -> grant order 0,1,2,3,0; each rsp_valid goes to the matching requester.
REQ-034 Timeout: spi_done never asserted with TIMEOUT=255 -> rsp_valid exactly 255 WAIT cycles after spi_start, rsp_err=1, rsp_data=0x00, cs_sel returns to 0.
REQ-035 spi_busy=1 in IDLE with requests pending -> no req_ready until spi_busy=0; spi_done pulse in IDLE -> no rsp_valid.
REQ-036 rst_n low during WAIT -> cs_sel, spi_tx_data, spi_start 0 immediately; no rsp_valid; first grant after release goes to requester 0.
REQ-037 spi_done on the same cycle the timeout count is reached -> rsp_err=0, rsp_data equals spi_rx_data.
